// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: FSM states, scancode width, prefix bytes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam int SC_W = 8;

  // Prefix bytes that downstream scancode decoders look for.
  localparam logic [SC_W-1:0] SC_EXT = 8'hE0;
  localparam logic [SC_W-1:0] SC_BRK = 8'hF0;

  // True when the data byte plus its parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [SC_W-1:0] b, input logic p);
    return ^{b, p};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: head entry is visible on rd_dat while not empty.
// Latency: a push is visible on rd_dat the edge after it is accepted; pop advances the head on its edge.
// Backpressure: push while full is dropped unless a pop is accepted the same cycle; pop while empty is ignored.
// Ports: fclk/rst clock and async active-high reset; push/wr_dat write side;
//        pop/rd_dat read side; full, empty, count (0..DEPTH) status.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int WIDTH = 8
) (
  input  logic             fclk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  // Extra pointer bit distinguishes full from empty; subtraction wraps naturally.
  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  assign do_pop  = pop & ~empty;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign do_push = push & (~full | do_pop);

  // Outputs read 0 while empty so stale entries never leak out after reset.
  assign rd_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge fclk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with clock glitch filter, frame watchdog, error flags and scancode FIFO.
// Latency: byte lands in the FIFO 2 sync + FILTER filter + 1 strobe + 1 push cycles after the stop-bit clock fall.
// Backpressure: none toward the device; a good byte arriving to a full FIFO (no pop that cycle) is dropped and flagged.
// Ports: fclk/rst clock and async active-high reset; ps2_clk/ps2_data raw pins;
//        rd pops one entry; data_ready/scancode/count show FIFO head and occupancy;
//        parity_err/frame_err/overflow sticky flags, cleared by clr_err.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int FILTER  = 4,
  parameter int TIMEOUT = 5000
) (
  input  logic            fclk,
  input  logic            rst,
  input  logic            ps2_clk,
  input  logic            ps2_data,
  input  logic            rd,
  input  logic            clr_err,
  output logic            data_ready,
  output logic [SC_W-1:0] scancode,
  output logic [AW:0]     count,
  output logic            parity_err,
  output logic            frame_err,
  output logic            overflow
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]      clk_s;
  logic [1:0]      dat_s;
  logic            filt_clk;
  logic            filt_prev;
  logic [FW-1:0]   filt_cnt;
  logic            strobe;
  logic            data_bit;

  ps2_state_t      state_q, state_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [SC_W-1:0] shift_q, shift_d;
  logic            perr_q, perr_d;
  logic            push_q, push_d;
  logic [TW-1:0]   to_cnt;
  logic            timeout;
  logic            set_perr;
  logic            set_ferr;

  logic            fifo_full;
  logic            fifo_empty;
  logic            pop_ok;

  // Two-flop synchronisers; idle-high reset value so no false edge after reset.
  // The filtered clock only follows the synchronised clock after FILTER
  // consecutive samples disagree with it; any agreeing sample restarts the run.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      clk_s     <= 2'b11;
      dat_s     <= 2'b11;
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      clk_s     <= {clk_s[0], ps2_clk};
      dat_s     <= {dat_s[0], ps2_data};
      filt_prev <= filt_clk;
      if (clk_s[1] == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER - 1)) begin
        filt_clk <= clk_s[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign strobe   = filt_prev & ~filt_clk;
  assign data_bit = dat_s[1];

  // A strobe on the expiry cycle keeps the frame alive.
  assign timeout = (state_q != IDLE) && (to_cnt == TW'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    perr_d   = perr_q;
    push_d   = 1'b0;
    set_perr = 1'b0;
    set_ferr = 1'b0;
    if (strobe) begin
      case (state_q)
        IDLE: begin
          if (!data_bit) begin
            state_d  = DATA;
            bitcnt_d = '0;
          end
        end
        DATA: begin
          shift_d[bitcnt_q] = data_bit;
          bitcnt_d          = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          perr_d  = ~odd_parity_ok(shift_q, data_bit);
          state_d = STOP;
        end
        STOP: begin
          state_d  = IDLE;
          push_d   = data_bit & ~perr_q;
          set_ferr = ~data_bit;
          set_perr = perr_q;
        end
        default: state_d = IDLE;
      endcase
    end else if (timeout) begin
      state_d  = IDLE;
      set_ferr = 1'b1;
    end
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      perr_q   <= 1'b0;
      push_q   <= 1'b0;
      to_cnt   <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      perr_q   <= perr_d;
      push_q   <= push_d;
      if (strobe || timeout || state_q == IDLE) to_cnt <= '0;
      else                                     to_cnt <= to_cnt + TW'(1);
    end
  end

  assign pop_ok = rd & ~fifo_empty;

  // shift_q holds the finished byte until the next frame's first data bit,
  // long after the registered push has consumed it.
  sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .WIDTH (SC_W)
  ) u_fifo (
    .fclk   (fclk),
    .rst    (rst),
    .push   (push_q),
    .wr_dat (shift_q),
    .pop    (rd),
    .rd_dat (scancode),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (count)
  );

  assign data_ready = ~fifo_empty;

  // Set beats clear so an event coinciding with clr_err is never lost.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (set_perr)     parity_err <= 1'b1;
      else if (clr_err) parity_err <= 1'b0;
      if (set_ferr)     frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
      if (push_q && fifo_full && !pop_ok) overflow <= 1'b1;
      else if (clr_err)                   overflow <= 1'b0;
    end
  end

endmodule
